// File: rtl/reg_file_if.sv
// Register file bus: ROB commit/rename ports, decoder source queries,
// ROB tag lookup and the resolved operands returned to the decoder.
interface reg_file_if #(
  parameter int ROB_SIZE_BIT = 5
);
  // ROB head commit
  logic                    commit_valid;
  logic [4:0]              commit_reg_id;
  logic [31:0]             commit_val;
  logic [ROB_SIZE_BIT-1:0] commit_rob_id;

  // ROB tail allocation (reg id 0 = no rename)
  logic [4:0]              rename_reg_id;
  logic [ROB_SIZE_BIT-1:0] rename_rob_id;

  // decoder source queries
  logic [4:0]              dec_rs1_id;
  logic [4:0]              dec_rs2_id;

  // tag lookup into the ROB and its answer
  logic [ROB_SIZE_BIT-1:0] rob_rs1_id;
  logic [ROB_SIZE_BIT-1:0] rob_rs2_id;
  logic                    rob_rs1_ready;
  logic                    rob_rs2_ready;
  logic [31:0]             rob_rs1_val;
  logic [31:0]             rob_rs2_val;

  // resolved operands
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic [31:0]             rs1_val;
  logic [31:0]             rs2_val;
  logic [ROB_SIZE_BIT-1:0] rs1_tag;
  logic [ROB_SIZE_BIT-1:0] rs2_tag;

  // decoder/ROB side
  modport master (
    output commit_valid, commit_reg_id, commit_val, commit_rob_id,
    output rename_reg_id, rename_rob_id,
    output dec_rs1_id, dec_rs2_id,
    output rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    input  rob_rs1_id, rob_rs2_id,
    input  rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
  );

  // register file side
  modport slave (
    input  commit_valid, commit_reg_id, commit_val, commit_rob_id,
    input  rename_reg_id, rename_rob_id,
    input  dec_rs1_id, dec_rs2_id,
    input  rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    output rob_rs1_id, rob_rs2_id,
    output rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with rename (busy/tag) tracking for an
// out-of-order core. 32 entries, x0 hardwired to zero. Source queries
// resolve combinationally against registered state and the ROB answer.
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards a same-cycle commit
// directly to a query that is waiting on that exact tag.
module reg_file #(
  parameter int ROB_SIZE_BIT = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_flag,
  reg_file_if.slave   bus
);

  typedef struct packed {
    logic                    busy;
    logic [31:0]             val;
    logic [ROB_SIZE_BIT-1:0] tag;
    logic [ROB_SIZE_BIT-1:0] rob_id;
  } query_t;

  logic [31:0][31:0]             value;
  logic [31:0]                   busy;
  logic [31:0][ROB_SIZE_BIT-1:0] tag;

  logic   bypass1;
  logic   bypass2;
  query_t q1;
  query_t q2;

  // Resolve one source operand from its register entry and the ROB answer.
  function automatic query_t resolve(
    input logic [4:0]              id,
    input logic [31:0]             e_val,
    input logic                    e_busy,
    input logic [ROB_SIZE_BIT-1:0] e_tag,
    input logic                    rob_ready,
    input logic [31:0]             rob_val,
    input logic                    bypass,
    input logic [31:0]             commit_val
  );
    query_t q;
    q = '0;
    if (id == 5'd0) begin
      q = '0;
    end else if (!e_busy) begin
      q.val = e_val;
    end else begin
      q.rob_id = e_tag;
      if (bypass) begin
        q.val = commit_val;
      end else if (rob_ready) begin
        q.val = rob_val;
      end else begin
        q.busy = 1'b1;
        q.tag  = e_tag;
      end
    end
    return q;
  endfunction

  // Detect a same-cycle commit that completes the tag a query is waiting on.
`ifdef REGFILE_COMMIT_BYPASS_EN
  always_comb begin
    bypass1 = bus.commit_valid && (bus.commit_reg_id == bus.dec_rs1_id) &&
              (bus.commit_rob_id == tag[bus.dec_rs1_id]);
    bypass2 = bus.commit_valid && (bus.commit_reg_id == bus.dec_rs2_id) &&
              (bus.commit_rob_id == tag[bus.dec_rs2_id]);
  end
`else
  always_comb begin
    bypass1 = 1'b0;
    bypass2 = 1'b0;
  end
`endif

  // Combinational operand resolution for both decoder source ports.
  always_comb begin
    q1 = resolve(bus.dec_rs1_id, value[bus.dec_rs1_id], busy[bus.dec_rs1_id],
                 tag[bus.dec_rs1_id], bus.rob_rs1_ready, bus.rob_rs1_val,
                 bypass1, bus.commit_val);
    q2 = resolve(bus.dec_rs2_id, value[bus.dec_rs2_id], busy[bus.dec_rs2_id],
                 tag[bus.dec_rs2_id], bus.rob_rs2_ready, bus.rob_rs2_val,
                 bypass2, bus.commit_val);
  end

  // Drive the query results onto the bus.
  always_comb begin
    bus.rob_rs1_id = q1.rob_id;
    bus.rs1_busy   = q1.busy;
    bus.rs1_val    = q1.val;
    bus.rs1_tag    = q1.tag;
    bus.rob_rs2_id = q2.rob_id;
    bus.rs2_busy   = q2.busy;
    bus.rs2_val    = q2.val;
    bus.rs2_tag    = q2.tag;
  end

  // Register state: commit writes value and retires a matching rename,
  // rename marks the entry busy, flush drops every pending rename.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      value <= '0;
      busy  <= '0;
      tag   <= '0;
    end else if (rdy_in) begin
      if (clear_flag) begin
        busy <= '0;
        tag  <= '0;
      end else begin
        if (bus.commit_valid && (bus.commit_reg_id != 5'd0)) begin
          value[bus.commit_reg_id] <= bus.commit_val;
          if (busy[bus.commit_reg_id] &&
              (tag[bus.commit_reg_id] == bus.commit_rob_id)) begin
            busy[bus.commit_reg_id] <= 1'b0;
          end
        end
        // Placed after the commit so a same-register rename overrides the busy clear.
        if (bus.rename_reg_id != 5'd0) begin
          busy[bus.rename_reg_id] <= 1'b1;
          tag[bus.rename_reg_id]  <= bus.rename_rob_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by a
// randomized phase, all compared against a behavioural register model.
module tb_reg_file;
  localparam int RB = 5;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_flag;

  reg_file_if #(.ROB_SIZE_BIT(RB)) bus ();

  reg_file #(.ROB_SIZE_BIT(RB)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear_flag (clear_flag),
    .bus        (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // reference architectural state
  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RB-1:0] m_tag  [32];

  typedef struct {
    logic          busy;
    logic [31:0]   val;
    logic [RB-1:0] tag;
    logic [RB-1:0] rob;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  // Apply one clock edge's worth of architectural effect.
  task automatic model_clock();
    int cr, rr;
    if (!rdy_in) return;
    if (clear_flag) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
      return;
    end
    cr = int'(bus.commit_reg_id);
    rr = int'(bus.rename_reg_id);
    if (bus.commit_valid && cr != 0) begin
      m_val[cr] = bus.commit_val;
      if (m_busy[cr] && m_tag[cr] == bus.commit_rob_id) m_busy[cr] = 1'b0;
    end
    if (rr != 0) begin
      m_busy[rr] = 1'b1;
      m_tag[rr]  = bus.rename_rob_id;
    end
  endtask

  function automatic exp_t expect_q(input logic [4:0] id, input logic ready, input logic [31:0] rval);
    exp_t e;
    int r;
    r = int'(id);
    e = '{busy: 1'b0, val: 32'd0, tag: '0, rob: '0};
    if (r == 0) return e;
    if (!m_busy[r]) begin
      e.val = m_val[r];
      return e;
    end
    e.rob = m_tag[r];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (bus.commit_valid && bus.commit_reg_id == id && bus.commit_rob_id == m_tag[r]) begin
      e.val = bus.commit_val;
      return e;
    end
`endif
    if (ready) e.val = rval;
    else begin
      e.busy = 1'b1;
      e.tag  = m_tag[r];
    end
    return e;
  endfunction

  task automatic check_queries(input string where);
    exp_t e1, e2;
    e1 = expect_q(bus.dec_rs1_id, bus.rob_rs1_ready, bus.rob_rs1_val);
    e2 = expect_q(bus.dec_rs2_id, bus.rob_rs2_ready, bus.rob_rs2_val);
    chk({where, ".rs1_busy"},   32'(bus.rs1_busy),   32'(e1.busy));
    chk({where, ".rs1_val"},    bus.rs1_val,         e1.val);
    chk({where, ".rs1_tag"},    32'(bus.rs1_tag),    32'(e1.tag));
    chk({where, ".rob_rs1_id"}, 32'(bus.rob_rs1_id), 32'(e1.rob));
    chk({where, ".rs2_busy"},   32'(bus.rs2_busy),   32'(e2.busy));
    chk({where, ".rs2_val"},    bus.rs2_val,         e2.val);
    chk({where, ".rs2_tag"},    32'(bus.rs2_tag),    32'(e2.tag));
    chk({where, ".rob_rs2_id"}, 32'(bus.rob_rs2_id), 32'(e2.rob));
  endtask

  task automatic idle();
    rdy_in            = 1'b1;
    clear_flag        = 1'b0;
    bus.commit_valid  = 1'b0;
    bus.commit_reg_id = '0;
    bus.commit_val    = '0;
    bus.commit_rob_id = '0;
    bus.rename_reg_id = '0;
    bus.rename_rob_id = '0;
    bus.dec_rs1_id    = '0;
    bus.dec_rs2_id    = '0;
    bus.rob_rs1_ready = 1'b0;
    bus.rob_rs2_ready = 1'b0;
    bus.rob_rs1_val   = '0;
    bus.rob_rs2_val   = '0;
  endtask

  // Inputs are set at a falling edge; check, clock, return at next falling edge.
  task automatic step(input string where);
    #1 check_queries(where);
    @(posedge clk_in);
    model_clock();
    @(negedge clk_in);
  endtask

  task automatic commit(input logic [4:0] r, input logic [RB-1:0] t, input logic [31:0] v);
    bus.commit_valid  = 1'b1;
    bus.commit_reg_id = r;
    bus.commit_rob_id = t;
    bus.commit_val    = v;
  endtask

  task automatic rename(input logic [4:0] r, input logic [RB-1:0] t);
    bus.rename_reg_id = r;
    bus.rename_rob_id = t;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(3) == 0) return 5'($urandom_range(31));
    return 5'($urandom_range(9));
  endfunction

  initial begin
    // reset with rdy low: state clears regardless
    idle();
    rdy_in = 1'b0;
    rst_in = 1'b0;
    model_reset();
    bus.dec_rs1_id = 5'd5;
    bus.dec_rs2_id = 5'd31;
    bus.rob_rs1_ready = 1'b1;
    bus.rob_rs1_val   = 32'hFFFF_FFFF;
    #2 check_queries("reset");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    // query x5 after reset
    idle();
    bus.dec_rs1_id = 5'd5;
    #1;
    chk("x5_after_reset.busy", 32'(bus.rs1_busy), 32'd0);
    chk("x5_after_reset.val",  bus.rs1_val,       32'd0);
    step("q_reset");

    // rename x5 -> tag 3, same-cycle query must not see it
    idle();
    rename(5'd5, RB'(3));
    bus.dec_rs1_id = 5'd5;
    step("rename_x5");

    idle();
    bus.dec_rs1_id = 5'd5;
    #1;
    chk("x5_busy.rob_id", 32'(bus.rob_rs1_id), 32'd3);
    chk("x5_busy.busy",   32'(bus.rs1_busy),   32'd1);
    chk("x5_busy.tag",    32'(bus.rs1_tag),    32'd3);
    bus.rob_rs1_ready = 1'b1;
    bus.rob_rs1_val   = 32'h1234;
    #1;
    chk("x5_rob_ready.busy", 32'(bus.rs1_busy), 32'd0);
    chk("x5_rob_ready.val",  bus.rs1_val,       32'h1234);
    step("x5_ready");

    // older commit must not clear a younger rename
    idle(); rename(5'd7, RB'(2)); step("x7_t2");
    idle(); rename(5'd7, RB'(4)); step("x7_t4");
    idle(); commit(5'd7, RB'(2), 32'hAA); bus.dec_rs1_id = 5'd7; step("x7_c2");
    idle(); bus.dec_rs1_id = 5'd7;
    #1;
    chk("x7_after_old_commit.busy", 32'(bus.rs1_busy), 32'd1);
    chk("x7_after_old_commit.tag",  32'(bus.rs1_tag),  32'd4);
    commit(5'd7, RB'(4), 32'hBB);
    step("x7_c4");
    idle(); bus.dec_rs2_id = 5'd7;
    #1;
    chk("x7_done.busy", 32'(bus.rs2_busy), 32'd0);
    chk("x7_done.val",  bus.rs2_val,       32'hBB);
    step("x7_done");

    // same-cycle commit and rename of x9
    idle(); commit(5'd9, RB'(1), 32'h55); rename(5'd9, RB'(6)); step("x9_both");
    idle(); bus.dec_rs1_id = 5'd9;
    #1;
    chk("x9.busy", 32'(bus.rs1_busy), 32'd1);
    chk("x9.tag",  32'(bus.rs1_tag),  32'd6);
    step("x9_q");

    // flush with pending renames; flushed-cycle commit/rename ignored
    idle(); rename(5'd1, RB'(1)); step("r1");
    idle(); rename(5'd2, RB'(2)); step("r2");
    idle(); rename(5'd3, RB'(3)); step("r3");
    idle(); clear_flag = 1'b1; commit(5'd1, RB'(1), 32'hDEAD); rename(5'd4, RB'(9)); step("flush");
    idle(); bus.dec_rs1_id = 5'd1; bus.dec_rs2_id = 5'd9;
    #1;
    chk("flush_x1.busy", 32'(bus.rs1_busy), 32'd0);
    chk("flush_x1.val",  bus.rs1_val,       32'd0);
    chk("flush_x9.val",  bus.rs2_val,       32'h55);
    step("post_flush");
    idle(); bus.dec_rs1_id = 5'd3; bus.dec_rs2_id = 5'd4; step("post_flush2");
    idle(); commit(5'd0, RB'(0), 32'hFF); rename(5'd0, RB'(7)); step("x0_write");
    idle(); bus.dec_rs1_id = 5'd0;
    bus.rob_rs1_ready = 1'b1; bus.rob_rs1_val = 32'h99;
    #1;
    chk("x0.busy", 32'(bus.rs1_busy), 32'd0);
    chk("x0.val",  bus.rs1_val,       32'd0);
    step("x0_q");

`ifdef REGFILE_COMMIT_BYPASS_EN
    idle(); rename(5'd4, RB'(5)); step("x4_t5");
    idle(); commit(5'd4, RB'(5), 32'h77); bus.dec_rs1_id = 5'd4;
    bus.rob_rs1_ready = 1'b1; bus.rob_rs1_val = 32'h1;
    #1;
    chk("bypass.busy", 32'(bus.rs1_busy), 32'd0);
    chk("bypass.val",  bus.rs1_val,       32'h77);
    step("bypass");
`endif

    // rdy low freezes state
    idle(); rdy_in = 1'b0; rename(5'd6, RB'(7)); commit(5'd9, RB'(0), 32'h1); step("frozen");
    idle(); bus.dec_rs1_id = 5'd6; bus.dec_rs2_id = 5'd9;
    #1;
    chk("frozen_x6.busy", 32'(bus.rs1_busy), 32'd0);
    step("frozen_q");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] cr;
      idle();
      rdy_in     = ($urandom_range(7) != 0);
      clear_flag = ($urandom_range(24) == 0);
      cr = pick_reg();
      bus.commit_valid  = ($urandom_range(1) == 1);
      bus.commit_reg_id = cr;
      bus.commit_val    = $urandom;
      bus.commit_rob_id = ($urandom_range(2) != 0 && m_busy[int'(cr)]) ? m_tag[int'(cr)] : RB'($urandom);
      bus.rename_reg_id = ($urandom_range(2) == 0) ? 5'd0 : pick_reg();
      bus.rename_rob_id = RB'($urandom);
      bus.dec_rs1_id    = ($urandom_range(1) == 1) ? cr : pick_reg();
      bus.dec_rs2_id    = pick_reg();
      bus.rob_rs1_ready = ($urandom_range(1) == 1);
      bus.rob_rs2_ready = ($urandom_range(1) == 1);
      bus.rob_rs1_val   = $urandom;
      bus.rob_rs2_val   = $urandom;
      step("rand");
    end

    // asynchronous reset mid-operation
    idle(); rename(5'd2, RB'(3)); step("pre_rst1");
    idle(); rename(5'd8, RB'(4)); commit(5'd8, RB'(0), 32'h42); step("pre_rst2");
    idle(); bus.dec_rs1_id = 5'd2; bus.dec_rs2_id = 5'd8;
    #2 rst_in = 1'b0;
    model_reset();
    #1 check_queries("mid_reset");
    chk("mid_reset.rs1_busy", 32'(bus.rs1_busy), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(); bus.dec_rs1_id = 5'd2; bus.dec_rs2_id = 5'd8; step("after_reset");
    idle(); rename(5'd2, RB'(1)); step("restart_rename");
    idle(); bus.dec_rs1_id = 5'd2; step("restart_q");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
